schmidl_cox_sequencer: RTL and testbench

- Control and configuration sequencer for the Schmidl-Cox detector datapath. Holds the detector's threshold, packet length and output-select settings, and applies them only at safe points.
- Arms the detector, pulses its clear input, and counts completed OFDM packets via the detector's end-of-packet pulse.
- Supports single-shot and continuous capture, a sample-count holdoff between packets, and an optional watchdog timeout.
- Sits between the block's register interface and the detector instance.

---
 rtl/schmidl_cox_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_schmidl_cox_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/schmidl_cox_sequencer.sv
// Control/configuration sequencer for the Schmidl-Cox detector: shadow registers, clear/arm FSM, packet counting.
// Optional sample-count watchdog is built when SCHMIDL_COX_SEQ_TIMEOUT_EN is defined.
module schmidl_cox_sequencer #(
  parameter int unsigned CLEAR_CYCLES      = 2,
  parameter logic [31:0] DEFAULT_THRESHOLD = 32'h0000_1000,
  parameter logic [31:0] DEFAULT_PKT_LEN   = 32'd1024,
  parameter int unsigned CNT_WIDTH         = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_wr_stb,
  input  logic        cfg_rd_stb,
  input  logic [7:0]  cfg_addr,
  input  logic [31:0] cfg_wr_data,
  output logic [31:0] cfg_rd_data,
  output logic        cfg_rd_ack,
  input  logic        sample_beat,
  input  logic        end_of_ofdm_packet,
  output logic [31:0] threshold,
  output logic [31:0] packet_length,
  output logic [1:0]  output_select,
  output logic        det_clear,
  output logic        det_enable,
  output logic        pkt_done,
  output logic [1:0]  state
);
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CLEARING = 2'd1,
    S_ARMED    = 2'd2,
    S_HOLDOFF  = 2'd3
  } state_t;

  localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);

  state_t               r_state, w_next;
  logic [CLR_W-1:0]     r_clr_cnt;
  logic                 r_exit_idle, w_exit_idle, w_start_clr;
  logic [31:0]          r_thr_sh, r_len_sh, r_hold_sh, r_hold_cnt;
  logic [1:0]           r_sel_sh;
  logic                 r_cont;
  logic [CNT_WIDTH-1:0] r_det_cnt;
  logic                 r_pkt_done;
  logic [31:0]          r_threshold, r_packet_length;
  logic [1:0]           r_output_select;
  logic                 r_rd_ack;
  logic [31:0]          r_rd_data, w_rd_val;
  logic                 w_wr_ctrl, w_arm, w_abort, w_cont, w_pkt, w_cnt_clr;
  logic                 w_timeout, w_timeout_flag;
  logic [31:0]          w_timeout_reg;

  assign w_wr_ctrl = cfg_wr_stb && (cfg_addr == 8'h00);
  assign w_arm     = w_wr_ctrl && cfg_wr_data[0];
  assign w_abort   = w_wr_ctrl && cfg_wr_data[2];
  // A CONTINUOUS write in the same cycle as a packet end steers that decision.
  assign w_cont    = w_wr_ctrl ? cfg_wr_data[1] : r_cont;
  assign w_pkt     = (r_state == S_ARMED) && end_of_ofdm_packet;
  assign w_cnt_clr = cfg_wr_stb && (cfg_addr == 8'h1C);

`ifdef SCHMIDL_COX_SEQ_TIMEOUT_EN
  logic [31:0] r_timeout_sh, r_beat_cnt, w_beat_nxt;
  logic        r_timeout_flag;

  assign w_beat_nxt = r_beat_cnt + 32'd1;
  // A packet end or an abort in the same cycle takes precedence over the watchdog.
  assign w_timeout  = (r_state == S_ARMED) && !end_of_ofdm_packet && !w_abort && sample_beat &&
                      (r_timeout_sh != 32'd0) && (w_beat_nxt == r_timeout_sh);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_timeout_sh   <= 32'd0;
      r_beat_cnt     <= 32'd0;
      r_timeout_flag <= 1'b0;
    end else begin
      if (cfg_wr_stb && (cfg_addr == 8'h14)) r_timeout_sh <= cfg_wr_data;
      if (r_state != S_ARMED) r_beat_cnt <= 32'd0;
      else if (sample_beat)   r_beat_cnt <= w_beat_nxt;
      if (w_cnt_clr)      r_timeout_flag <= 1'b0;
      else if (w_timeout) r_timeout_flag <= 1'b1;
    end
  end

  assign w_timeout_reg  = r_timeout_sh;
  assign w_timeout_flag = r_timeout_flag;
`else
  assign w_timeout      = 1'b0;
  assign w_timeout_reg  = 32'd0;
  assign w_timeout_flag = 1'b0;
`endif

  always_comb begin
    w_next      = r_state;
    w_start_clr = 1'b0;
    w_exit_idle = r_exit_idle;
    if (w_abort) begin
      w_start_clr = 1'b1;
      w_exit_idle = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: if (w_arm) begin
          w_start_clr = 1'b1;
          w_exit_idle = 1'b0;
        end
        S_CLEARING: if (r_clr_cnt == CLR_W'(1)) w_next = r_exit_idle ? S_IDLE : S_ARMED;
        S_ARMED: begin
          if (w_pkt) begin
            if (!w_cont)                    w_next = S_IDLE;
            else if (r_hold_sh != 32'd0)    w_next = S_HOLDOFF;
            else begin
              w_start_clr = 1'b1;
              w_exit_idle = 1'b0;
            end
          end else if (w_timeout) begin
            w_start_clr = 1'b1;
            w_exit_idle = !w_cont;
          end
        end
        S_HOLDOFF: if (sample_beat && (r_hold_cnt <= 32'd1)) begin
          w_start_clr = 1'b1;
          w_exit_idle = 1'b0;
        end
        default: w_next = S_IDLE;
      endcase
    end
    if (w_start_clr) w_next = S_CLEARING;
  end

  always_comb begin
    w_rd_val = 32'd0;
    case (cfg_addr)
      8'h04:   w_rd_val = r_thr_sh;
      8'h08:   w_rd_val = r_len_sh;
      8'h0C:   w_rd_val = {30'd0, r_sel_sh};
      8'h10:   w_rd_val = r_hold_sh;
      8'h14:   w_rd_val = w_timeout_reg;
      8'h18:   w_rd_val = {28'd0, w_timeout_flag, r_cont, r_state};
      8'h1C:   w_rd_val = 32'(r_det_cnt);
      default: w_rd_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_clr_cnt       <= CLR_W'(CLEAR_CYCLES);
      r_exit_idle     <= 1'b0;
      r_thr_sh        <= DEFAULT_THRESHOLD;
      r_len_sh        <= DEFAULT_PKT_LEN;
      r_sel_sh        <= 2'd0;
      r_hold_sh       <= 32'd0;
      r_hold_cnt      <= 32'd0;
      r_cont          <= 1'b0;
      r_det_cnt       <= '0;
      r_pkt_done      <= 1'b0;
      r_threshold     <= DEFAULT_THRESHOLD;
      r_packet_length <= DEFAULT_PKT_LEN;
      r_output_select <= 2'd0;
      r_rd_ack        <= 1'b0;
      r_rd_data       <= 32'd0;
    end else begin
      r_state     <= w_next;
      r_exit_idle <= w_exit_idle;
      // Applied settings are refreshed only at the start of a clear sequence.
      if (w_start_clr) begin
        r_clr_cnt       <= CLR_W'(CLEAR_CYCLES);
        r_threshold     <= r_thr_sh;
        r_packet_length <= r_len_sh;
        r_output_select <= r_sel_sh;
      end else if (r_clr_cnt != '0) begin
        r_clr_cnt <= r_clr_cnt - CLR_W'(1);
      end
      if ((r_state == S_ARMED) && (w_next == S_HOLDOFF)) r_hold_cnt <= r_hold_sh;
      else if ((r_state == S_HOLDOFF) && sample_beat)     r_hold_cnt <= r_hold_cnt - 32'd1;
      r_pkt_done <= w_pkt;
      if (w_cnt_clr)                      r_det_cnt <= '0;
      else if (w_pkt && (r_det_cnt != '1)) r_det_cnt <= r_det_cnt + CNT_WIDTH'(1);
      if (w_wr_ctrl) r_cont <= cfg_wr_data[1];
      if (cfg_wr_stb) begin
        case (cfg_addr)
          8'h04:   r_thr_sh  <= cfg_wr_data;
          8'h08:   r_len_sh  <= cfg_wr_data;
          8'h0C:   r_sel_sh  <= cfg_wr_data[1:0];
          8'h10:   r_hold_sh <= cfg_wr_data;
          default: ;
        endcase
      end
      r_rd_ack  <= cfg_rd_stb;
      r_rd_data <= cfg_rd_stb ? w_rd_val : 32'd0;
    end
  end

  assign state         = r_state;
  assign det_enable    = (r_state == S_ARMED);
  assign det_clear     = (r_clr_cnt != '0);
  assign pkt_done      = r_pkt_done;
  assign threshold     = r_threshold;
  assign packet_length = r_packet_length;
  assign output_select = r_output_select;
  assign cfg_rd_ack    = r_rd_ack;
  assign cfg_rd_data   = r_rd_data;
endmodule

// File: tb/tb_schmidl_cox_sequencer.sv
// Self-checking bench for schmidl_cox_sequencer: per-cycle model comparison plus directed literal checks.
module tb_schmidl_cox_sequencer;
  localparam int CLR = 2;
`ifdef SCHMIDL_COX_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, cfg_wr_stb, cfg_rd_stb, sample_beat, end_of_ofdm_packet;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_wr_data, cfg_rd_data, threshold, packet_length;
  logic        cfg_rd_ack, det_clear, det_enable, pkt_done;
  logic [1:0]  output_select, state;

  int n_checks = 0;
  int n_fail   = 0;

  schmidl_cox_sequencer #(.CLEAR_CYCLES(CLR)) dut (
    .clk(clk), .reset(reset), .cfg_wr_stb(cfg_wr_stb), .cfg_rd_stb(cfg_rd_stb),
    .cfg_addr(cfg_addr), .cfg_wr_data(cfg_wr_data), .cfg_rd_data(cfg_rd_data),
    .cfg_rd_ack(cfg_rd_ack), .sample_beat(sample_beat),
    .end_of_ofdm_packet(end_of_ofdm_packet), .threshold(threshold),
    .packet_length(packet_length), .output_select(output_select),
    .det_clear(det_clear), .det_enable(det_enable), .pkt_done(pkt_done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: plain variables describing what the block must present after each edge.
  int          m_state, m_clr, m_nstate;
  logic [31:0] m_hold, m_beats, m_cnt;
  bit          m_exit_idle, m_cont, m_flag, m_pkt, m_ack, m_live = 1'b0;
  bit          e_ctrl, e_arm, e_abort, e_cont, e_pkt, e_tmo, e_clear, e_idle;
  logic [31:0] m_thr, m_len, sh_thr, sh_len, sh_hold, sh_to, m_rdata;
  logic [1:0]  m_sel, sh_sel;

  function automatic logic [31:0] model_read(input logic [7:0] a);
    case (a)
      8'h04:   return sh_thr;
      8'h08:   return sh_len;
      8'h0C:   return {30'd0, sh_sel};
      8'h10:   return sh_hold;
      8'h14:   return TO_EN ? sh_to : 32'd0;
      8'h18:   return 32'(m_state) + (m_cont ? 32'd4 : 32'd0) + (m_flag ? 32'd8 : 32'd0);
      8'h1C:   return m_cnt;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_live = 1'b1; m_state = 0; m_clr = CLR; m_exit_idle = 1'b0;
      m_thr = 32'h1000; m_len = 32'd1024; m_sel = 2'd0;
      sh_thr = 32'h1000; sh_len = 32'd1024; sh_sel = 2'd0; sh_hold = 0; sh_to = 0;
      m_cont = 0; m_flag = 0; m_pkt = 0; m_ack = 0; m_rdata = 0;
      m_cnt = 0; m_hold = 0; m_beats = 0;
    end else begin
      e_ctrl  = cfg_wr_stb && (cfg_addr == 8'h00);
      e_arm   = e_ctrl && cfg_wr_data[0];
      e_abort = e_ctrl && cfg_wr_data[2];
      e_cont  = e_ctrl ? cfg_wr_data[1] : m_cont;
      e_pkt   = (m_state == 2) && end_of_ofdm_packet;
      e_tmo   = TO_EN && (m_state == 2) && !e_pkt && !e_abort && sample_beat &&
                (sh_to != 0) && (m_beats + 1 == sh_to);
      m_ack   = cfg_rd_stb;
      m_rdata = cfg_rd_stb ? model_read(cfg_addr) : 32'd0;
      e_clear = 1'b0;
      e_idle  = m_exit_idle;
      m_nstate = m_state;
      if (e_abort) begin
        e_clear = 1'b1; e_idle = 1'b1;
      end else if (m_state == 0 && e_arm) begin
        e_clear = 1'b1; e_idle = 1'b0;
      end else if (m_state == 1 && m_clr == 1) begin
        m_nstate = m_exit_idle ? 0 : 2;
      end else if (e_pkt) begin
        if (!e_cont) m_nstate = 0;
        else if (sh_hold == 0) begin e_clear = 1'b1; e_idle = 1'b0; end
        else begin m_nstate = 3; m_hold = sh_hold; end
      end else if (e_tmo) begin
        e_clear = 1'b1; e_idle = !e_cont;
      end else if (m_state == 3 && sample_beat) begin
        m_hold = m_hold - 1;
        if (m_hold == 0) begin e_clear = 1'b1; e_idle = 1'b0; end
      end
      if (m_clr > 0) m_clr--;
      if (e_clear) begin
        m_clr = CLR; m_nstate = 1; m_exit_idle = e_idle;
        m_thr = sh_thr; m_len = sh_len; m_sel = sh_sel;
      end
      if (m_state != 2) m_beats = 0;
      else if (sample_beat) m_beats++;
      m_pkt = e_pkt;
      if (cfg_wr_stb && cfg_addr == 8'h1C) begin m_cnt = 0; m_flag = 0; end
      else begin
        if (e_pkt && m_cnt < 32'hFFFF) m_cnt++;
        if (e_tmo) m_flag = 1'b1;
      end
      if (e_ctrl) m_cont = cfg_wr_data[1];
      if (cfg_wr_stb) begin
        case (cfg_addr)
          8'h04: sh_thr  = cfg_wr_data;
          8'h08: sh_len  = cfg_wr_data;
          8'h0C: sh_sel  = cfg_wr_data[1:0];
          8'h10: sh_hold = cfg_wr_data;
          8'h14: sh_to   = cfg_wr_data;
          default: ;
        endcase
      end
      m_state = m_nstate;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("state", 32'(state), 32'(m_state));
      chk("det_clear", 32'(det_clear), 32'(m_clr > 0));
      chk("det_enable", 32'(det_enable), 32'(m_state == 2));
      chk("pkt_done", 32'(pkt_done), 32'(m_pkt));
      chk("threshold", threshold, m_thr);
      chk("packet_length", packet_length, m_len);
      chk("output_select", 32'(output_select), 32'(m_sel));
      chk("rd_ack", 32'(cfg_rd_ack), 32'(m_ack));
      chk("rd_data", cfg_rd_data, m_rdata);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cfg_wr_stb = 1'b1; cfg_addr = a; cfg_wr_data = d;
    tick(1);
    cfg_wr_stb = 1'b0; cfg_addr = 8'h00; cfg_wr_data = 32'd0;
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] a, input logic [31:0] exp);
    cfg_rd_stb = 1'b1; cfg_addr = a;
    tick(1);
    cfg_rd_stb = 1'b0; cfg_addr = 8'h00;
    chk({nm, "_ack"}, 32'(cfg_rd_ack), 32'd1);
    chk(nm, cfg_rd_data, exp);
  endtask

  task automatic pulse_eop();
    end_of_ofdm_packet = 1'b1; tick(1); end_of_ofdm_packet = 1'b0;
  endtask

  task automatic beat();
    sample_beat = 1'b1; tick(1); sample_beat = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; cfg_wr_stb = 0; cfg_rd_stb = 0; cfg_addr = 0; cfg_wr_data = 0;
    sample_beat = 0; end_of_ofdm_packet = 0;
    tick(3);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pkt_done", 32'(pkt_done), 32'd0);
    reset = 1'b0;
    chk("rel_clear0", 32'(det_clear), 32'd1);
    tick(1); chk("rel_clear1", 32'(det_clear), 32'd1);
    tick(1); chk("rel_clear2", 32'(det_clear), 32'd0);
    chk("rst_thr", threshold, 32'h1000);
    chk("rst_len", packet_length, 32'd1024);
    chk("rst_sel", 32'(output_select), 32'd0);
    rd_chk("rd_thr_default", 8'h04, 32'h1000);
    rd_chk("rd_len_default", 8'h08, 32'd1024);
    rd_chk("rd_unmapped", 8'h20, 32'd0);
    tick(1); chk("rd_idle_data", cfg_rd_data, 32'd0);

    // single-shot capture
    wr(8'h04, 32'h8000);
    chk("thr_hold_idle", threshold, 32'h1000);
    wr(8'h00, 32'h1);
    chk("arm_state", 32'(state), 32'd1);
    chk("arm_thr", threshold, 32'h8000);
    chk("arm_clear", 32'(det_clear), 32'd1);
    tick(1); chk("clr2_state", 32'(state), 32'd1);
    tick(1); chk("armed_state", 32'(state), 32'd2);
    chk("armed_en", 32'(det_enable), 32'd1);
    tick(3);
    pulse_eop();
    chk("ss_pkt_done", 32'(pkt_done), 32'd1);
    chk("ss_idle", 32'(state), 32'd0);
    tick(1); chk("ss_pkt_done_low", 32'(pkt_done), 32'd0);
    rd_chk("cnt_one", 8'h1C, 32'd1);

    // continuous with holdoff of five samples
    wr(8'h1C, 32'd0);
    rd_chk("cnt_cleared", 8'h1C, 32'd0);
    wr(8'h10, 32'd5);
    wr(8'h00, 32'h3);
    tick(2);
    rd_chk("status_cont_armed", 8'h18, 32'h6);
    for (int p = 0; p < 3; p++) begin
      pulse_eop();
      chk("ho_state", 32'(state), 32'd3);
      chk("ho_en", 32'(det_enable), 32'd0);
      for (int b = 0; b < 5; b++) begin
        tick(1);
        chk("ho_wait", 32'(state), 32'd3);
        beat();
      end
      chk("ho_to_clear", 32'(state), 32'd1);
      tick(2);
      chk("ho_rearmed", 32'(state), 32'd2);
    end
    rd_chk("cnt_three", 8'h1C, 32'd3);

    // shadow writes while armed wait for the next clear
    wr(8'h08, 32'd256);
    chk("len_hold", packet_length, 32'd1024);
    wr(8'h10, 32'd0);
    wr(8'h0C, 32'd2);
    tick(3);
    chk("len_hold2", packet_length, 32'd1024);
    chk("sel_hold", 32'(output_select), 32'd0);
    rd_chk("rd_sel", 8'h0C, 32'd2);
    pulse_eop();
    chk("direct_clear", 32'(state), 32'd1);
    chk("len_applied", packet_length, 32'd256);
    chk("sel_applied", 32'(output_select), 32'd2);
    tick(2);
    chk("rearm_direct", 32'(state), 32'd2);

    // abort beats arm in the same write
    wr(8'h00, 32'h5);
    chk("abort_clear", 32'(state), 32'd1);
    chk("abort_en", 32'(det_enable), 32'd0);
    tick(2);
    chk("abort_idle", 32'(state), 32'd0);
    wr(8'h1C, 32'd0);
    rd_chk("cnt_zero", 8'h1C, 32'd0);
    rd_chk("status_idle", 8'h18, 32'd0);

    // watchdog timeout, single shot
    wr(8'h14, 32'd10);
    rd_chk("rd_timeout", 8'h14, TO_EN ? 32'd10 : 32'd0);
    wr(8'h00, 32'h1);
    tick(2);
    for (int i = 0; i < 10; i++) beat();
    chk("to_state", 32'(state), TO_EN ? 32'd1 : 32'd2);
    rd_chk("to_status", 8'h18, TO_EN ? 32'h9 : 32'h2);
    tick(2);
    chk("to_final", 32'(state), TO_EN ? 32'd0 : 32'd2);
    rd_chk("to_cnt", 8'h1C, 32'd0);
    wr(8'h00, 32'h4);
    tick(2);
    wr(8'h1C, 32'd0);
    wr(8'h00, 32'h1);
    tick(2);
    for (int i = 0; i < 9; i++) beat();
    sample_beat = 1'b1; end_of_ofdm_packet = 1'b1;
    tick(1);
    sample_beat = 1'b0; end_of_ofdm_packet = 1'b0;
    chk("tie_pkt_done", 32'(pkt_done), 32'd1);
    chk("tie_idle", 32'(state), 32'd0);
    rd_chk("tie_status", 8'h18, 32'd0);
    rd_chk("tie_cnt", 8'h1C, 32'd1);

    // reset in the middle of a capture
    wr(8'h04, 32'h1234);
    wr(8'h00, 32'h3);
    tick(2);
    chk("pre_rst_thr", threshold, 32'h1234);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_thr", threshold, 32'h1000);
    chk("mid_rst_clear", 32'(det_clear), 32'd1);
    rd_chk("mid_rst_shadow", 8'h04, 32'h1000);
    rd_chk("mid_rst_status", 8'h18, 32'd0);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
